// File: rtl/frogger_game_fsm.sv
// frogger_game_fsm: round/score/lives controller for Frogger.
// Watches per-pixel frog and car draw flags for overlap, closes each frame on
// i_Frame_Start, and freezes play for a fixed number of frames after a hit or
// a successful crossing.
// Optional feature: define TIMEOUT_EN to add a per-attempt frame timer. When
// it expires, the frog loses a life exactly as if it had been hit.
//
// state     | meaning
// IDLE      | power-up, waiting for a start press
// RUNNING   | frog may move; collisions and goal row are evaluated per frame
// HIT       | frog was hit (or timed out); frozen for c_HIT_FRAMES frames
// WIN       | frog reached the goal row; frozen for c_WIN_FRAMES frames
// GAME_OVER | no lives left or score limit reached; waiting for start press
module frogger_game_fsm #(
    parameter int c_LIVES       = 3,
    parameter int c_SCORE_LIMIT = 99,
    parameter int c_GOAL_ROW    = 0,
    parameter int c_HIT_FRAMES  = 60,
    parameter int c_WIN_FRAMES  = 30,
    parameter int c_TIME_LIMIT  = 600
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Game_Start,
    input  logic       i_Frame_Start,
    input  logic       i_Active_Video,
    input  logic       i_Draw_Frogger,
    input  logic       i_Draw_Car_Any,
    input  logic [5:0] i_Frogger_Y,
    output logic       o_Game_Active,
    output logic       o_Frog_Reset,
    output logic [6:0] o_Score,
    output logic [1:0] o_Lives,
    output logic [2:0] o_State
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUNNING   = 3'd1,
        HIT       = 3'd2,
        WIN       = 3'd3,
        GAME_OVER = 3'd4
    } t_state;

    localparam logic [1:0] c_LIVES_INIT = 2'(c_LIVES);
    localparam logic [6:0] c_SCORE_MAX  = 7'(c_SCORE_LIMIT);
    localparam logic [5:0] c_GOAL       = 6'(c_GOAL_ROW);
    localparam logic [5:0] c_HIT_LOAD   = 6'(c_HIT_FRAMES);
    localparam logic [5:0] c_WIN_LOAD   = 6'(c_WIN_FRAMES);

    t_state     r_State;
    t_state     w_Next_State;
    logic       r_Start_Prev;
    logic       r_Coll_Latch;
    logic [5:0] r_Frame_Cnt;
    logic [6:0] r_Score;
    logic [1:0] r_Lives;
    logic       r_Game_Active;
    logic       r_Frog_Reset;

    logic       w_Start_Edge;
    logic       w_Pixel_Hit;
    logic       w_Timeout;
    logic       w_Collision;
    logic       w_Enter_Run;
    logic [5:0] w_Frame_Cnt_Next;
    logic [6:0] w_Score_Next;
    logic [1:0] w_Lives_Next;

    assign w_Start_Edge = i_Game_Start & ~r_Start_Prev;
    assign w_Pixel_Hit  = i_Active_Video & i_Draw_Frogger & i_Draw_Car_Any;
    // A pixel overlap on the frame-start cycle itself still belongs to the closing frame.
    assign w_Collision  = r_Coll_Latch | w_Pixel_Hit | w_Timeout;
    assign w_Enter_Run  = (w_Next_State == RUNNING) && (r_State != RUNNING);

`ifdef TIMEOUT_EN
    localparam logic [9:0] c_TIME_LOAD = 10'(c_TIME_LIMIT);
    logic [9:0] r_Attempt_Cnt;

    assign w_Timeout = (r_State == RUNNING) && i_Frame_Start && (r_Attempt_Cnt == 10'd1);

    // Attempt timer: reloaded on every entry to RUNNING, counts down once per frame.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Attempt_Cnt <= 10'd0;
        end else if (w_Enter_Run) begin
            r_Attempt_Cnt <= c_TIME_LOAD;
        end else if ((r_State == RUNNING) && i_Frame_Start && (r_Attempt_Cnt != 10'd0)) begin
            r_Attempt_Cnt <= r_Attempt_Cnt - 10'd1;
        end
    end
`else
    assign w_Timeout = 1'b0;
`endif

    // State, counters and registered outputs.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State       <= IDLE;
            r_Start_Prev  <= 1'b0;
            r_Frame_Cnt   <= 6'd0;
            r_Score       <= 7'd0;
            r_Lives       <= c_LIVES_INIT;
            r_Game_Active <= 1'b0;
            r_Frog_Reset  <= 1'b0;
        end else begin
            r_State       <= w_Next_State;
            r_Start_Prev  <= i_Game_Start;
            r_Frame_Cnt   <= w_Frame_Cnt_Next;
            r_Score       <= w_Score_Next;
            r_Lives       <= w_Lives_Next;
            r_Game_Active <= (w_Next_State == RUNNING);
            r_Frog_Reset  <= w_Enter_Run;
        end
    end

    // Collision latch: only armed in RUNNING, consumed at every frame start.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Coll_Latch <= 1'b0;
        end else if ((r_State != RUNNING) || i_Frame_Start) begin
            r_Coll_Latch <= 1'b0;
        end else if (w_Pixel_Hit) begin
            r_Coll_Latch <= 1'b1;
        end
    end

    // Next-state, frame down-counter, score and lives update.
    always_comb begin
        w_Next_State     = r_State;
        w_Frame_Cnt_Next = r_Frame_Cnt;
        w_Score_Next     = r_Score;
        w_Lives_Next     = r_Lives;
        case (r_State)
            IDLE, GAME_OVER: begin
                if (w_Start_Edge) begin
                    w_Next_State = RUNNING;
                    w_Score_Next = 7'd0;
                    w_Lives_Next = c_LIVES_INIT;
                end
            end
            RUNNING: begin
                if (i_Frame_Start) begin
                    if (w_Collision) begin
                        w_Next_State     = HIT;
                        w_Frame_Cnt_Next = c_HIT_LOAD;
                        if (r_Lives != 2'd0) begin
                            w_Lives_Next = r_Lives - 2'd1;
                        end
                    end else if (i_Frogger_Y == c_GOAL) begin
                        w_Next_State     = WIN;
                        w_Frame_Cnt_Next = c_WIN_LOAD;
                        if (r_Score < c_SCORE_MAX) begin
                            w_Score_Next = r_Score + 7'd1;
                        end
                    end
                end
            end
            HIT: begin
                if (i_Frame_Start) begin
                    if (r_Frame_Cnt <= 6'd1) begin
                        w_Next_State     = (r_Lives == 2'd0) ? GAME_OVER : RUNNING;
                        w_Frame_Cnt_Next = 6'd0;
                    end else begin
                        w_Frame_Cnt_Next = r_Frame_Cnt - 6'd1;
                    end
                end
            end
            WIN: begin
                if (i_Frame_Start) begin
                    if (r_Frame_Cnt <= 6'd1) begin
                        w_Next_State     = (r_Score == c_SCORE_MAX) ? GAME_OVER : RUNNING;
                        w_Frame_Cnt_Next = 6'd0;
                    end else begin
                        w_Frame_Cnt_Next = r_Frame_Cnt - 6'd1;
                    end
                end
            end
            default: begin
                w_Next_State = IDLE;
            end
        endcase
    end

    assign o_Game_Active = r_Game_Active;
    assign o_Frog_Reset  = r_Frog_Reset;
    assign o_Score       = r_Score;
    assign o_Lives       = r_Lives;
    assign o_State       = r_State;

endmodule

// File: tb/tb_frogger_game_fsm.sv
// tb_frogger_game_fsm: directed bench for frogger_game_fsm.
// Frames are compressed to a few clocks each; TIMEOUT_EN builds use a 5-frame limit.
module tb_frogger_game_fsm;

    logic       i_Clk          = 1'b0;
    logic       i_Rst_L        = 1'b1;
    logic       i_Game_Start   = 1'b0;
    logic       i_Frame_Start  = 1'b0;
    logic       i_Active_Video = 1'b0;
    logic       i_Draw_Frogger = 1'b0;
    logic       i_Draw_Car_Any = 1'b0;
    logic [5:0] i_Frogger_Y    = 6'd5;
    logic       o_Game_Active;
    logic       o_Frog_Reset;
    logic [6:0] o_Score;
    logic [1:0] o_Lives;
    logic [2:0] o_State;

    int n_checks = 0;
    int n_fails  = 0;
    int pulses;

    always #5 i_Clk = ~i_Clk;

    frogger_game_fsm #(.c_TIME_LIMIT(5)) u_dut (
        .i_Clk          (i_Clk),
        .i_Rst_L        (i_Rst_L),
        .i_Game_Start   (i_Game_Start),
        .i_Frame_Start  (i_Frame_Start),
        .i_Active_Video (i_Active_Video),
        .i_Draw_Frogger (i_Draw_Frogger),
        .i_Draw_Car_Any (i_Draw_Car_Any),
        .i_Frogger_Y    (i_Frogger_Y),
        .o_Game_Active  (o_Game_Active),
        .o_Frog_Reset   (o_Frog_Reset),
        .o_Score        (o_Score),
        .o_Lives        (o_Lives),
        .o_State        (o_State)
    );

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic frame();
        @(negedge i_Clk);
        i_Frame_Start = 1'b1;
        @(negedge i_Clk);
        i_Frame_Start = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int k = 0; k < n; k++) frame();
    endtask

    task automatic pixel_hit();
        @(negedge i_Clk);
        i_Active_Video = 1'b1;
        i_Draw_Frogger = 1'b1;
        i_Draw_Car_Any = 1'b1;
        @(negedge i_Clk);
        i_Active_Video = 1'b0;
        i_Draw_Frogger = 1'b0;
        i_Draw_Car_Any = 1'b0;
    endtask

    task automatic start_press();
        @(negedge i_Clk);
        i_Game_Start = 1'b1;
        @(negedge i_Clk);
        i_Game_Start = 1'b0;
    endtask

    initial begin
        // Asynchronous reset with no clock edge in between.
        #2 i_Rst_L = 1'b0;
        #2;
        check("rst_state", o_State, 0);
        check("rst_lives", o_Lives, 3);
        check("rst_score", o_Score, 0);
        check("rst_active", o_Game_Active, 0);
        check("rst_frog_reset", o_Frog_Reset, 0);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;

        // Start edge, then hold the button for 1000 cycles.
        @(negedge i_Clk);
        i_Game_Start = 1'b1;
        @(negedge i_Clk);
        check("start_state", o_State, 1);
        check("start_frog_reset", o_Frog_Reset, 1);
        check("start_active", o_Game_Active, 1);
        @(negedge i_Clk);
        check("start_pulse_width", o_Frog_Reset, 0);
        pulses = 0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge i_Clk);
            pulses += int'(o_Frog_Reset);
        end
        check("hold_no_repulse", pulses, 0);
        check("hold_state", o_State, 1);
        i_Game_Start = 1'b0;

        // Near misses: overlap outside active video, frog without car.
        i_Frogger_Y = 6'd5;
        @(negedge i_Clk);
        i_Active_Video = 1'b0; i_Draw_Frogger = 1'b1; i_Draw_Car_Any = 1'b1;
        @(negedge i_Clk);
        i_Active_Video = 1'b1; i_Draw_Frogger = 1'b1; i_Draw_Car_Any = 1'b0;
        @(negedge i_Clk);
        i_Active_Video = 1'b0; i_Draw_Frogger = 1'b0;
        frame();
        check("miss_state", o_State, 1);
        check("miss_lives", o_Lives, 3);

        // One overlapping pixel; evaluated only at the frame start.
        pixel_hit();
        check("hit_pending_state", o_State, 1);
        frame();
        check("hit_state", o_State, 2);
        check("hit_lives", o_Lives, 2);
        check("hit_active", o_Game_Active, 0);
        frames(59);
        check("hit_frozen_59", o_State, 2);
        frame();
        check("hit_exit_state", o_State, 1);
        check("hit_exit_frog_reset", o_Frog_Reset, 1);

        // Goal row crossing.
        i_Frogger_Y = 6'd0;
        frame();
        check("win_state", o_State, 3);
        check("win_score", o_Score, 1);
        check("win_frog_reset", o_Frog_Reset, 0);
        frames(29);
        check("win_frozen_29", o_State, 3);
        frame();
        check("win_exit_state", o_State, 1);
        check("win_exit_frog_reset", o_Frog_Reset, 1);

        // Goal and overlap in the same frame: collision wins.
        pixel_hit();
        frame();
        check("prio_state", o_State, 2);
        check("prio_score", o_Score, 1);
        check("prio_lives", o_Lives, 1);

        // Overlap while in HIT is ignored after returning to RUNNING.
        pixel_hit();
        frames(60);
        check("hit2_exit_state", o_State, 1);
        i_Frogger_Y = 6'd5;
        frame();
        check("no_stale_coll_state", o_State, 1);
        check("no_stale_coll_lives", o_Lives, 1);

        // Overlap on the frame-start cycle counts for that frame.
        @(negedge i_Clk);
        i_Frame_Start = 1'b1;
        i_Active_Video = 1'b1; i_Draw_Frogger = 1'b1; i_Draw_Car_Any = 1'b1;
        @(negedge i_Clk);
        i_Frame_Start = 1'b0;
        i_Active_Video = 1'b0; i_Draw_Frogger = 1'b0; i_Draw_Car_Any = 1'b0;
        check("same_cycle_state", o_State, 2);
        check("same_cycle_lives", o_Lives, 0);

        // Start edge during HIT is ignored.
        frames(10);
        @(negedge i_Clk);
        i_Game_Start = 1'b1;
        @(negedge i_Clk);
        check("start_in_hit_state", o_State, 2);
        check("start_in_hit_lives", o_Lives, 0);
        i_Game_Start = 1'b0;
        frames(50);
        check("over_state", o_State, 4);
        check("over_active", o_Game_Active, 0);
        check("over_frog_reset", o_Frog_Reset, 0);
        check("over_lives", o_Lives, 0);

        // Restart from GAME_OVER.
        @(negedge i_Clk);
        i_Game_Start = 1'b1;
        @(negedge i_Clk);
        check("restart_state", o_State, 1);
        check("restart_lives", o_Lives, 3);
        check("restart_score", o_Score, 1 - 1);
        check("restart_frog_reset", o_Frog_Reset, 1);
        i_Game_Start = 1'b0;

        // Score once, then reset asynchronously mid-RUNNING.
        i_Frogger_Y = 6'd0;
        frame();
        frames(30);
        check("pre_rst_score", o_Score, 1);
        check("pre_rst_state", o_State, 1);
        @(negedge i_Clk);
        #2 i_Rst_L = 1'b0;
        #1;
        check("midrst_state", o_State, 0);
        check("midrst_score", o_Score, 0);
        check("midrst_lives", o_Lives, 3);
        check("midrst_active", o_Game_Active, 0);
        check("midrst_frog_reset", o_Frog_Reset, 0);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;

        // Run the score up to the limit.
        start_press();
        i_Frogger_Y = 6'd0;
        for (int k = 0; k < 98; k++) begin
            frame();
            frames(30);
        end
        check("score_98", o_Score, 98);
        check("score_98_state", o_State, 1);
        frame();
        check("score_99", o_Score, 99);
        check("score_99_state", o_State, 3);
        frames(29);
        check("limit_frozen", o_State, 3);
        frame();
        check("limit_over_state", o_State, 4);
        check("limit_over_score", o_Score, 99);
        check("limit_over_frog_reset", o_Frog_Reset, 0);

        // Idle frames in RUNNING: timeout only when the timer is built in.
        start_press();
        i_Frogger_Y = 6'd5;
        frames(4);
        check("idle4_state", o_State, 1);
        frame();
`ifdef TIMEOUT_EN
        check("timeout_state", o_State, 2);
        check("timeout_lives", o_Lives, 2);
`else
        check("no_timeout_state", o_State, 1);
        check("no_timeout_lives", o_Lives, 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
